// File: rtl/pc_unit.sv
// Program-counter stage: resolves branch/jal/jalr from ALU flags, holds the PC and
// retired-instruction count, and halts the core on a misaligned control-transfer target.
module pc_unit #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch,
    input  logic        jump,
    input  logic        jumpReg,
    input  logic [2:0]  funct3,
    input  logic        zero,
    input  logic        sign,
    input  logic [31:0] immExt,
    input  logic [31:0] aluResult,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic [31:0] pcTarget,
    output logic        taken,
    output logic        misaligned,
    output logic        halted,
    output logic [31:0] instret
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instret_q, instret_d;
    logic        cond_s;
    logic [31:0] target_s;

    assign pcPlus4  = pc_q + 32'd4;
    assign pcTarget = pc_q + immExt;

    // Branch condition decode; blt/bge use the raw sign flag without overflow correction.
    always_comb begin
        cond_s = 1'b0;
        case (funct3)
            3'b000:  cond_s = zero;
            3'b001:  cond_s = ~zero;
            3'b100:  cond_s = sign;
            3'b101:  cond_s = ~sign;
            default: cond_s = 1'b0;
        endcase
    end

    // Next-PC select with jalr > jal > branch priority.
    always_comb begin
        target_s = pcPlus4;
        if (jumpReg) begin
            target_s = {aluResult[31:1], 1'b0};
        end else if (jump || (branch && cond_s)) begin
            target_s = pcTarget;
        end else begin
            target_s = pcPlus4;
        end
    end

    assign taken      = jumpReg | jump | (branch & cond_s);
    assign misaligned = taken & target_s[1];

    // RUN/HALT next-state and PC/instret update; HALT is only left through reset.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        case (state_q)
            ST_RUN: begin
                if (stall) begin
                    state_d = ST_RUN;
                end else if (misaligned) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d      = target_s;
                    instret_d = instret_q + 32'd1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    // State registers with synchronous reset overriding stall and HALT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_VEC;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
        end
    end

    assign pc      = pc_q;
    assign instret = instret_q;
    assign halted  = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized cycles checked
// against an arithmetic reference model of the PC stage.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset, stall, branch, jump, jumpReg, zero, sign;
    logic [2:0]  funct3;
    logic [31:0] immExt, aluResult;
    logic [31:0] pc, pcPlus4, pcTarget, instret;
    logic        taken, misaligned, halted;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instret;
    logic        m_halted;

    always #5 clk = ~clk;

    pc_unit #(.RESET_VEC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch), .jump(jump),
        .jumpReg(jumpReg), .funct3(funct3), .zero(zero), .sign(sign),
        .immExt(immExt), .aluResult(aluResult), .pc(pc), .pcPlus4(pcPlus4),
        .pcTarget(pcTarget), .taken(taken), .misaligned(misaligned),
        .halted(halted), .instret(instret)
    );

    function automatic logic m_cond();
        return branch && ((funct3 == 3'd0 && zero) || (funct3 == 3'd1 && !zero) ||
                          (funct3 == 3'd4 && sign) || (funct3 == 3'd5 && !sign));
    endfunction

    function automatic logic m_taken();
        return jumpReg || jump || m_cond();
    endfunction

    function automatic logic [31:0] m_target();
        if (jumpReg) return aluResult & 32'hFFFF_FFFE;
        if (jump || m_cond()) return m_pc + immExt;
        return m_pc + 32'd4;
    endfunction

    function automatic logic m_mis();
        logic [31:0] t;
        t = m_target();
        return m_taken() && t[1];
    endfunction

    task automatic drive_idle();
        reset = 1'b0; stall = 1'b0; branch = 1'b0; jump = 1'b0; jumpReg = 1'b0;
        funct3 = 3'd0; zero = 1'b0; sign = 1'b0; immExt = 32'd0; aluResult = 32'd0;
    endtask

    // One rising edge; the model advances from the inputs present at that edge.
    task automatic clock_cycle();
        logic [31:0] nt;
        logic        mis;
        @(posedge clk);
        nt  = m_target();
        mis = m_mis();
        if (reset) begin
            m_pc = 32'd0; m_instret = 32'd0; m_halted = 1'b0;
        end else if (!m_halted && !stall) begin
            if (mis) m_halted = 1'b1;
            else begin
                m_pc = nt; m_instret = m_instret + 32'd1;
            end
        end
        #1;
    endtask

    task automatic set_pc(input logic [31:0] target);
        drive_idle();
        jump   = 1'b1;
        immExt = target - m_pc;
        clock_cycle();
        drive_idle();
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        clock_cycle();
        reset = 1'b0;
        #1;
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        vectors++; if (instret !== 32'd0) begin miscompares++; $display("FAIL reset_instret: got %0d want 0", instret); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", halted); end
        for (int i = 1; i <= 3; i++) begin
            clock_cycle();
            vectors++;
            if (pc !== 32'(4 * i)) begin miscompares++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, 32'(4 * i)); end
        end
        vectors++; if (instret !== 32'd3) begin miscompares++; $display("FAIL seq_instret: got %0d want 3", instret); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL seq_halted: got %b want 0", halted); end
    endtask

    task automatic test_branch();
        set_pc(32'h10);
        branch = 1'b1; funct3 = 3'b000; zero = 1'b1; immExt = 32'hFFFF_FFF8;
        #1;
        vectors++; if (taken !== 1'b1) begin miscompares++; $display("FAIL beq_taken: got %b want 1", taken); end
        vectors++; if (pcTarget !== 32'h8) begin miscompares++; $display("FAIL beq_pctarget: got %h want %h", pcTarget, 32'h8); end
        vectors++; if (pcPlus4 !== 32'h14) begin miscompares++; $display("FAIL beq_pcplus4: got %h want %h", pcPlus4, 32'h14); end
        clock_cycle();
        vectors++; if (pc !== 32'h8) begin miscompares++; $display("FAIL beq_pc: got %h want %h", pc, 32'h8); end
        set_pc(32'h10);
        branch = 1'b1; funct3 = 3'b000; zero = 1'b0; immExt = 32'hFFFF_FFF8;
        #1;
        vectors++; if (taken !== 1'b0) begin miscompares++; $display("FAIL beq_nt_taken: got %b want 0", taken); end
        clock_cycle();
        vectors++; if (pc !== 32'h14) begin miscompares++; $display("FAIL beq_nt_pc: got %h want %h", pc, 32'h14); end
        set_pc(32'h10);
        branch = 1'b1; funct3 = 3'b001; zero = 1'b0; immExt = 32'h0000_0030;
        clock_cycle();
        vectors++; if (pc !== 32'h40) begin miscompares++; $display("FAIL bne_pc: got %h want %h", pc, 32'h40); end
    endtask

    task automatic test_blt_bge();
        logic [2:0] f3s [3];
        logic [31:0] want [3];
        f3s[0] = 3'b100; want[0] = 32'h120;
        f3s[1] = 3'b101; want[1] = 32'h104;
        f3s[2] = 3'b110; want[2] = 32'h104;
        for (int i = 0; i < 3; i++) begin
            set_pc(32'h100);
            branch = 1'b1; funct3 = f3s[i]; sign = 1'b1; immExt = 32'h20;
            clock_cycle();
            vectors++;
            if (pc !== want[i]) begin miscompares++; $display("FAIL signed_br_f3_%0d: got %h want %h", f3s[i], pc, want[i]); end
        end
    endtask

    task automatic test_jump_priority_halt();
        logic [31:0] ir;
        drive_idle();
        jumpReg = 1'b1; jump = 1'b1; aluResult = 32'h0000_0201; immExt = 32'h40;
        #1;
        vectors++; if (misaligned !== 1'b0) begin miscompares++; $display("FAIL jalr_prio_mis: got %b want 0", misaligned); end
        clock_cycle();
        vectors++; if (pc !== 32'h200) begin miscompares++; $display("FAIL jalr_prio_pc: got %h want %h", pc, 32'h200); end
        ir = m_instret;
        drive_idle();
        jumpReg = 1'b1; aluResult = 32'h206;
        #1;
        vectors++; if (misaligned !== 1'b1) begin miscompares++; $display("FAIL jalr_mis: got %b want 1", misaligned); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL pre_halt: got %b want 0", halted); end
        clock_cycle();
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_set: got %b want 1", halted); end
        vectors++; if (pc !== 32'h200) begin miscompares++; $display("FAIL halt_pc_hold: got %h want %h", pc, 32'h200); end
        drive_idle();
        jump = 1'b1; immExt = 32'h80;
        for (int i = 0; i < 5; i++) begin
            clock_cycle();
            vectors++;
            if (pc !== 32'h200 || instret !== ir || halted !== 1'b1) begin
                miscompares++;
                $display("FAIL halt_frozen%0d: got pc=%h instret=%0d halted=%b want pc=%h instret=%0d halted=1", i, pc, instret, halted, 32'h200, ir);
            end
        end
        vectors++; if (pcTarget !== 32'h280) begin miscompares++; $display("FAIL halt_comb_target: got %h want %h", pcTarget, 32'h280); end
    endtask

    task automatic test_stall_reset();
        logic [31:0] p0, ir;
        drive_idle();
        stall = 1'b1; jump = 1'b1; immExt = 32'h80;
        clock_cycle(); clock_cycle();
        vectors++; if (pc !== 32'h200) begin miscompares++; $display("FAIL stall_halt_pc: got %h want %h", pc, 32'h200); end
        reset = 1'b1;
        clock_cycle();
        reset = 1'b0;
        #1;
        vectors++;
        if (pc !== 32'h0 || instret !== 32'd0 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_over_halt: got pc=%h instret=%0d halted=%b want 0/0/0", pc, instret, halted);
        end
        set_pc(32'h40);
        p0 = m_pc; ir = m_instret;
        stall = 1'b1; jump = 1'b1; immExt = 32'h80;
        clock_cycle(); clock_cycle();
        vectors++;
        if (pc !== p0 || instret !== ir) begin
            miscompares++;
            $display("FAIL stall_run: got pc=%h instret=%0d want pc=%h instret=%0d", pc, instret, p0, ir);
        end
        drive_idle();
        stall = 1'b1; jumpReg = 1'b1; aluResult = 32'h6;
        clock_cycle();
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL stall_mis_ignored: got %b want 0", halted); end
        drive_idle();
    endtask

    task automatic test_wrap();
        set_pc(32'hFFFF_FFFC);
        #1;
        vectors++; if (pcPlus4 !== 32'h0) begin miscompares++; $display("FAIL wrap_pcplus4: got %h want %h", pcPlus4, 32'h0); end
        clock_cycle();
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL wrap_seq_pc: got %h want %h", pc, 32'h0); end
        set_pc(32'hFFFF_FFF8);
        branch = 1'b1; funct3 = 3'b000; zero = 1'b1; immExt = 32'h8;
        clock_cycle();
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL wrap_br_pc: got %h want %h", pc, 32'h0); end
        drive_idle();
    endtask

    task automatic test_random();
        drive_idle();
        reset = 1'b1;
        clock_cycle();
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 31) == 0);
            stall     = ($urandom_range(0, 7) == 0);
            branch    = $urandom_range(0, 1);
            jump      = ($urandom_range(0, 5) == 0);
            jumpReg   = ($urandom_range(0, 7) == 0);
            funct3    = 3'($urandom_range(0, 7));
            zero      = $urandom_range(0, 1);
            sign      = $urandom_range(0, 1);
            immExt    = $urandom();
            aluResult = $urandom();
            if ($urandom_range(0, 7) != 0) immExt = immExt & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) != 0) aluResult = aluResult & 32'hFFFF_FFFD;
            #1;
            vectors++;
            if (taken !== m_taken() || misaligned !== m_mis() ||
                pcPlus4 !== m_pc + 32'd4 || pcTarget !== m_pc + immExt) begin
                miscompares++;
                $display("FAIL rand_comb%0d: got taken=%b mis=%b p4=%h tgt=%h want taken=%b mis=%b p4=%h tgt=%h",
                         i, taken, misaligned, pcPlus4, pcTarget, m_taken(), m_mis(), m_pc + 32'd4, m_pc + immExt);
            end
            clock_cycle();
            vectors++;
            if (pc !== m_pc || instret !== m_instret || halted !== m_halted) begin
                miscompares++;
                $display("FAIL rand_state%0d: got pc=%h instret=%0d halted=%b want pc=%h instret=%0d halted=%b",
                         i, pc, instret, halted, m_pc, m_instret, m_halted);
            end
        end
        drive_idle();
    endtask

    initial begin
        m_pc = 32'd0; m_instret = 32'd0; m_halted = 1'b0;
        drive_idle();
        #1;
        test_reset();
        test_branch();
        test_blt_bge();
        test_jump_priority_halt();
        test_stall_reset();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
